clk_switch_ctrl: RTL and testbench
==================================

// Module: clk_switch_ctrl
// PURPOSE
//   Sequencer that drives the select input of the glitch-free clock mux and confirms each switch.
//   Runs on always-on reference clock clk0_i; accepts valid/ready switch requests.
//   Checks clk1_i liveness before switching to it, waits for the mux enables to hand over,
//   then reports completion or a coded error.
// PARAMETERS
//   SYNC_STAGES  2   flop stages syncing en1_i and the clk1 toggle into clk0_i (>=2)
//   ALIVE_WIN    16  clk0_i cycles allowed to observe clk1_i activity (>=4)
//   TIMEOUT_CYC  64  clk0_i cycles allowed for mux handover after sel_o change (>=8)
// PORTS
//   clk0_i       in   1  reference clock, also mux input clock 0
//   arst_ni      in   1  asynchronous reset, active-low
//   clk1_i       in   1  alternate clock; used only by the internal liveness toggle flop
//   req_valid_i  in   1  switch request valid
//   req_sel_i    in   1  requested source: 0=clk0, 1=clk1
//   req_ready_o  out  1  high in IDLE; request accepted on valid&&ready
//   sel_o        out  1  select to mux
//   en0_i        in   1  mux clk0 enable (clk0_i domain, used directly)
//   en1_i        in   1  mux clk1 enable (clk1_i domain, synced SYNC_STAGES)
//   cur_sel_o    out  1  last confirmed source
//   busy_o       out  1  high in CHECK or SWITCH
//   done_o       out  1  1-cycle pulse: switch confirmed or no-op
//   err_o        out  1  1-cycle pulse: switch failed
//   err_code_o   out  2  valid with err_o: 01=handover timeout, 10=clk1 dead; held until next err_o
// BEHAVIOUR
//   Reset (async assert, clk0_i-synchronous release): state=IDLE, sel_o=0, cur_sel_o=0,
//     busy_o=0, done_o=0, err_o=0, err_code_o=00, counters=0, sync flops=0.
//     req_ready_o=(state==IDLE), so it is 1 during reset.
//   Liveness: clk1_i toggles t1 (reset 0) on every posedge; t1 is synced into clk0_i;
//     every change of the synced value is one "edge".
//   IDLE: on accept, req_sel_i is latched as tgt.
//     - tgt==cur_sel_o: done_o pulses next cycle; stay IDLE; sel_o unchanged.
//     - tgt==1: go to CHECK; clear window counter and edge count.
//     - tgt==0: sel_o<=0; go to SWITCH; clear timeout counter.
//   CHECK: window counter increments each cycle.
//     - edge count reaches 2: sel_o<=1; go to SWITCH.
//     - counter reaches ALIVE_WIN-1 with <2 edges: err_o, err_code_o=10, go to IDLE; sel_o unchanged.
//     - Edge wins if both occur in the same cycle.
//   SWITCH: timeout counter increments each cycle.
//     - Done when the target enable (en0_i, or synced en1_i) is 1 and the other is 0:
//       cur_sel_o<=tgt, done_o pulses, go to IDLE.
//     - Counter reaches TIMEOUT_CYC-1 with no completion: err_o, err_code_o=01,
//       sel_o<=cur_sel_o (revert), go to IDLE.
//     - Completion wins if both occur in the same cycle.
//   Request rules:
//     - req_valid_i while not ready is ignored; requester holds it until accepted.
//     - A request can be accepted in the same cycle done_o or err_o is asserted.
//   done_o and err_o are never high together; busy_o = (state!=IDLE), so req_ready_o = !busy_o.
//   Reset mid-operation: immediate return to reset values; sel_o=0 drops the mux to clk0;
//     no done_o or err_o is generated.
//   Counters are sized $clog2(max(ALIVE_WIN,TIMEOUT_CYC)) bits and never wrap (bounded by FSM exit).
// TESTING
//   1. Reset, then clk1 at 3x clk0 period; request sel=1 -> sel_o=1 within ALIVE_WIN;
//      done_o once en1 sync=1 & en0=0; cur_sel_o=1.
//   2. clk1 held low; request sel=1 -> err_o at CHECK entry+16 cycles; err_code_o=10; sel_o stays 0.
//   3. From cur_sel_o=1, request sel=0 -> sel_o=0 next cycle; done_o after en0=1 & en1 sync=0; cur_sel_o=0.
//   4. Request sel=0 while cur_sel_o=0 -> done_o 1 cycle after accept; sel_o, busy_o unchanged.
//   5. Mux model stuck (en1 never rises) -> err_o at SWITCH entry+64 cycles; err_code_o=01; sel_o reverts to 0.
//   6. arst_ni low mid-SWITCH -> sel_o, cur_sel_o, busy_o =0 immediately; no done_o/err_o; req_ready_o=1.

Source files
------------

// File: rtl/clk_switch_ctrl.sv
// Clock-switch sequencer for a glitch-free mux: runs on clk0_i, checks clk1_i liveness,
// drives sel_o and confirms the enable handover, or reports a coded error.
module clk_switch_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ALIVE_WIN   = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic       clk0_i,
  input  logic       arst_ni,
  input  logic       clk1_i,
  input  logic       req_valid_i,
  input  logic       req_sel_i,
  output logic       req_ready_o,
  output logic       sel_o,
  input  logic       en0_i,
  input  logic       en1_i,
  output logic       cur_sel_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);

  localparam int unsigned CntMax = (ALIVE_WIN > TIMEOUT_CYC) ? ALIVE_WIN : TIMEOUT_CYC;
  localparam int unsigned CntW   = $clog2(CntMax);

  localparam logic [CntW-1:0] AliveLast   = CntW'(ALIVE_WIN - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCheck  = 2'd1;
  localparam logic [1:0] StSwitch = 2'd2;

  localparam logic [1:0] ErrTimeout = 2'b01;
  localparam logic [1:0] ErrDead    = 2'b10;

  // Liveness toggle in the clk1 domain; only its synchronised transitions are observed.
  logic t1_q;

  always_ff @(posedge clk1_i or negedge arst_ni) begin
    if (!arst_ni) begin
      t1_q <= 1'b0;
    end else begin
      t1_q <= ~t1_q;
    end
  end

  logic [SYNC_STAGES-1:0] t1_sync_q;
  logic [SYNC_STAGES-1:0] en1_sync_q;
  logic                   t1_prev_q;
  logic                   t1_edge;
  logic                   en1_synced;

  always_ff @(posedge clk0_i or negedge arst_ni) begin
    if (!arst_ni) begin
      t1_sync_q  <= '0;
      en1_sync_q <= '0;
      t1_prev_q  <= 1'b0;
    end else begin
      t1_sync_q  <= {t1_sync_q[SYNC_STAGES-2:0], t1_q};
      en1_sync_q <= {en1_sync_q[SYNC_STAGES-2:0], en1_i};
      t1_prev_q  <= t1_sync_q[SYNC_STAGES-1];
    end
  end

  assign t1_edge    = t1_sync_q[SYNC_STAGES-1] ^ t1_prev_q;
  assign en1_synced = en1_sync_q[SYNC_STAGES-1];

  logic [1:0]      state_q, state_d;
  logic            sel_q, sel_d;
  logic            cur_q, cur_d;
  logic            tgt_q, tgt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      edges_q, edges_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            handover_ok;

  // Handover is complete only once the target enable is on and the other is off.
  assign handover_ok = tgt_q ? (en1_synced && !en0_i) : (en0_i && !en1_synced);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    edges_d = edges_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          tgt_d = req_sel_i;
          if (req_sel_i == cur_q) begin
            done_d = 1'b1;
          end else if (req_sel_i) begin
            state_d = StCheck;
            cnt_d   = '0;
            edges_d = '0;
          end else begin
            sel_d   = 1'b0;
            state_d = StSwitch;
            cnt_d   = '0;
          end
        end
      end

      StCheck: begin
        edges_d = edges_q + {1'b0, t1_edge};
        // A second edge takes priority over the window running out.
        if (edges_d == 2'd2) begin
          sel_d   = 1'b1;
          state_d = StSwitch;
          cnt_d   = '0;
        end else if (cnt_q == AliveLast) begin
          err_d   = 1'b1;
          code_d  = ErrDead;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StSwitch: begin
        if (handover_ok) begin
          cur_d   = tgt_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          code_d  = ErrTimeout;
          sel_d   = cur_q;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk0_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      cur_q   <= 1'b0;
      tgt_q   <= 1'b0;
      cnt_q   <= '0;
      edges_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      edges_q <= edges_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign req_ready_o = ~busy_o;
  assign sel_o       = sel_q;
  assign cur_sel_o   = cur_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = code_q;

  done_err_excl_a: assert property (@(posedge clk0_i) disable iff (!arst_ni)
    !(done_o && err_o));

  err_code_legal_a: assert property (@(posedge clk0_i) disable iff (!arst_ni)
    err_o |-> (err_code_o == ErrTimeout || err_code_o == ErrDead));

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Randomised scoreboard bench for clk_switch_ctrl with a behavioural glitch-free mux model.
module tb_clk_switch_ctrl;

  localparam int unsigned ALIVE_WIN   = 16;
  localparam int unsigned TIMEOUT_CYC = 64;

  logic       clk0 = 1'b0;
  logic       clk1 = 1'b0;
  logic       clk1_run = 1'b1;
  logic       arst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_sel = 1'b0;
  logic       stuck1 = 1'b0;
  logic       req_ready, sel, cur_sel, busy, done, err;
  logic [1:0] err_code;
  logic       en0, en1;

  clk_switch_ctrl #(
    .SYNC_STAGES(2),
    .ALIVE_WIN  (ALIVE_WIN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_dut (
    .clk0_i     (clk0),
    .arst_ni    (arst_n),
    .clk1_i     (clk1),
    .req_valid_i(req_valid),
    .req_sel_i  (req_sel),
    .req_ready_o(req_ready),
    .sel_o      (sel),
    .en0_i      (en0),
    .en1_i      (en1),
    .cur_sel_o  (cur_sel),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .err_code_o (err_code)
  );

  always #5 clk0 = ~clk0;

  // clk1 runs at 3x the clk0 period; when stopped it always parks low.
  always begin
    #15;
    if (clk1_run || clk1) clk1 = ~clk1;
  end

  // Mux model: the old source's enable drops before the new one's rises.
  logic [1:0] en1_s0, sel_s1, en0_s1;

  always @(posedge clk0 or negedge arst_n) begin
    if (!arst_n) begin
      en0    <= 1'b0;
      en1_s0 <= 2'b00;
    end else begin
      en1_s0 <= {en1_s0[0], en1};
      en0    <= !sel && !en1_s0[1];
    end
  end

  always @(posedge clk1 or negedge arst_n) begin
    if (!arst_n) begin
      en1    <= 1'b0;
      sel_s1 <= 2'b00;
      en0_s1 <= 2'b00;
    end else begin
      sel_s1 <= {sel_s1[0], sel};
      en0_s1 <= {en0_s1[0], en0};
      en1    <= sel_s1[1] && !en0_s1[1] && !stuck1;
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk0) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // lat_kind: 0 exact from accept, 1 exact from sel_o rise, 2 upper bound from accept
  typedef struct {
    logic is_err;
    int   code;
    int   cur;
    int   lat_kind;
    int   lat;
  } exp_t;

  exp_t sb[$];
  int   cur_m = 0;
  int   last_code = 0;
  int   accept_cyc = 0;
  int   sel_rise_cyc = 0;
  logic sel_prev = 1'b0;

  always @(negedge clk0) begin
    exp_t e;
    if (!arst_n) begin
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
    end else begin
      if (sel && !sel_prev) sel_rise_cyc = cyc;
      if (done || err) begin
        chk("done_err_excl", int'(done && err), 0);
        if (sb.size() == 0) begin
          chk("unexpected_resp", int'(done) + int'(err), 0);
        end else begin
          e = sb.pop_front();
          chk("resp_is_err", err, e.is_err);
          if (e.is_err) begin
            chk("err_code", err_code, e.code);
            last_code = e.code;
          end else begin
            chk("err_code_held", err_code, last_code);
          end
          chk("cur_sel", cur_sel, e.cur);
          chk("sel_after", sel, e.cur);
          chk("busy_idle", busy, 0);
          chk("ready_idle", req_ready, 1);
          case (e.lat_kind)
            0: chk("lat_accept", cyc - accept_cyc, e.lat);
            1: chk("lat_switch", cyc - sel_rise_cyc, e.lat);
            default: begin
              chk("lat_bound", int'((cyc - accept_cyc) <= e.lat), 1);
              if (e.cur == 1) chk("sel_rise_win", int'((sel_rise_cyc - accept_cyc) <= ALIVE_WIN), 1);
            end
          endcase
        end
      end
    end
    sel_prev = sel;
  end

  task automatic issue(input int s);
    exp_t e;
    bit   acc;
    int   guard;
    @(negedge clk0);
    req_valid = 1'b1;
    req_sel   = s[0];
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 400) begin
      acc = req_ready;
      @(posedge clk0);
      #1;
      guard++;
      if (!acc) @(negedge clk0);
    end
    req_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", int'(acc), 1);
      return;
    end
    accept_cyc = cyc;
    if (s == cur_m) begin
      e = '{1'b0, 0, cur_m, 0, 0};
      chk("noop_busy", busy, 0);
    end else if (s == 1 && !clk1_run) begin
      e = '{1'b1, 2, cur_m, 0, ALIVE_WIN};
      chk("check_busy", busy, 1);
    end else if (s == 1 && stuck1) begin
      e = '{1'b1, 1, cur_m, 1, TIMEOUT_CYC};
      chk("check_busy", busy, 1);
    end else begin
      cur_m = s;
      e = '{1'b0, 0, s, 2, ALIVE_WIN + TIMEOUT_CYC};
      chk("switch_busy", busy, 1);
      if (s == 0) chk("sel_drop_next", sel, 0);
    end
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 400) begin
      @(posedge clk0);
      #2;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    sb.delete();
  endtask

  // scen: 0 normal, 1 clk1 dead, 2 en1 stuck, 3 two chained normal requests
  task automatic run(input int s, input int scen);
    int sc = scen;
    if ((sc == 1 || sc == 2) && !(cur_m == 0 && s == 1)) sc = 0;
    if (sc == 1) begin
      clk1_run = 1'b0;
      repeat (8) @(negedge clk0);
    end
    if (sc == 2) stuck1 = 1'b1;
    issue(s);
    if (sc == 3) issue(int'($urandom_range(0, 1)));
    drain();
    clk1_run = 1'b1;
    stuck1   = 1'b0;
    repeat (10 + $urandom_range(0, 5)) @(negedge clk0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached limit 500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1;
    chk("rst_sel", sel, 0);
    chk("rst_cur_sel", cur_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_code", err_code, 0);
    repeat (3) @(negedge clk0);
    arst_n = 1'b1;
    repeat (5) @(negedge clk0);

    run(1, 0);  // switch to clk1
    run(0, 0);  // back to clk0
    run(0, 0);  // no-op
    run(1, 1);  // clk1 dead
    run(1, 2);  // handover stuck
    run(0, 3);  // chained

    for (int i = 0; i < 24; i++) begin
      run(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a stuck handover.
    if (cur_m != 0) run(0, 0);
    stuck1 = 1'b1;
    issue(1);
    n = 0;
    while (!sel && n < 100) begin
      @(negedge clk0);
      n++;
    end
    chk("sel_rose_before_reset", sel, 1);
    repeat (5) @(negedge clk0);
    #1;
    arst_n = 1'b0;
    sb.delete();
    cur_m = 0;
    last_code = 0;
    #1;
    chk("midrst_sel", sel, 0);
    chk("midrst_cur_sel", cur_sel, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_code", err_code, 0);
    repeat (3) @(negedge clk0);
    arst_n = 1'b1;
    stuck1 = 1'b0;
    repeat (20) @(negedge clk0);
    run(1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
